// File: rtl/exec_dispatch_pkg.sv
// exec_dispatch_pkg: shared types, error codes and the
// default opcode ranges of the execution dispatcher.
package exec_dispatch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    HALT
  } state_e;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_ILL = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;

  localparam int DEF_NUM_ELEM = 5;

  localparam int DEF_ELEM_LO [DEF_NUM_ELEM] =
    '{4, 8, 54, 32, 28};
  localparam int DEF_ELEM_HI [DEF_NUM_ELEM] =
    '{8, 28, 64, 48, 54};

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/exec_dispatch_if.sv
// exec_dispatch_if: instruction-in and result-out
// valid/ready channels of the dispatcher.
interface exec_dispatch_if
  import exec_dispatch_pkg::*;
#(
  parameter int NUM_ELEM = DEF_NUM_ELEM,
  parameter int XLEN     = 32,
  parameter int OP_W     = 6
);

  localparam int EW = idx_w(NUM_ELEM);

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [OP_W-1:0] in_op;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_reg;
  logic [XLEN-1:0] out_pc;
  logic [EW-1:0]   out_elem;
  logic [1:0]      out_err;

  modport master (
    output in_valid,
    output in_pc,
    output in_op,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_reg,
    input  out_pc,
    input  out_elem,
    input  out_err
  );

  modport slave (
    input  in_valid,
    input  in_pc,
    input  in_op,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_reg,
    output out_pc,
    output out_elem,
    output out_err
  );

endinterface

// File: rtl/exec_decode.sv
// exec_decode: opcode range match to an execution
// element; the lowest matching index wins.
module exec_decode
  import exec_dispatch_pkg::*;
#(
  parameter int NUM_ELEM = DEF_NUM_ELEM,
  parameter int OP_W     = 6,
  parameter int ELEM_LO [NUM_ELEM] = DEF_ELEM_LO,
  parameter int ELEM_HI [NUM_ELEM] = DEF_ELEM_HI
) (
  input  logic [OP_W-1:0]            op,
  output logic [idx_w(NUM_ELEM)-1:0] sel,
  output logic                       legal
);

  localparam int EW = idx_w(NUM_ELEM);

  // Scan high to low so the lowest hit is written last.
  always_comb begin
    sel   = '0;
    legal = 1'b0;
    for (int e = NUM_ELEM - 1; e >= 0; e--) begin
      if (int'(op) >= ELEM_LO[e] &&
          int'(op) <  ELEM_HI[e]) begin
        sel   = EW'(e);
        legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exec_dispatch.sv
// exec_dispatch: decodes an instruction, starts one
// execution element and returns its result or an error.
module exec_dispatch
  import exec_dispatch_pkg::*;
#(
  parameter int NUM_ELEM = DEF_NUM_ELEM,
  parameter int XLEN     = 32,
  parameter int OP_W     = 6,
  parameter int ELEM_LO [NUM_ELEM] = DEF_ELEM_LO,
  parameter int ELEM_HI [NUM_ELEM] = DEF_ELEM_HI,
  parameter int TIMEOUT  = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  exec_dispatch_if.slave           bus,
  output logic [NUM_ELEM-1:0]      elem_start,
  input  logic [NUM_ELEM-1:0]      elem_done,
  input  logic [NUM_ELEM*XLEN-1:0] elem_result,
  input  logic [NUM_ELEM-1:0]      elem_pc_valid,
  input  logic [NUM_ELEM*XLEN-1:0] elem_pc,
  input  logic                     halt_req,
  output logic                     halted
);

  localparam int EW = idx_w(NUM_ELEM);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(TIMEOUT - 1);

  state_e          state;
  logic [XLEN-1:0] pc_q;
  logic [EW-1:0]   sel_q;
  logic [CW-1:0]   cnt;
  logic            halt_q;

  logic [EW-1:0]   dec_sel;
  logic            dec_legal;

  logic            done_sel;
  logic            pcv_sel;
  logic [XLEN-1:0] res_sel;
  logic [XLEN-1:0] epc_sel;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] in_pc_inc;

  exec_decode #(
    .NUM_ELEM (NUM_ELEM),
    .OP_W     (OP_W),
    .ELEM_LO  (ELEM_LO),
    .ELEM_HI  (ELEM_HI)
  ) u_decode (
    .op    (bus.in_op),
    .sel   (dec_sel),
    .legal (dec_legal)
  );

  assign done_sel  = elem_done[sel_q];
  assign pcv_sel   = elem_pc_valid[sel_q];
  assign res_sel   =
    elem_result[int'(sel_q)*XLEN +: XLEN];
  assign epc_sel   =
    elem_pc[int'(sel_q)*XLEN +: XLEN];
  assign pc_inc    = pc_q + XLEN'(4);
  assign in_pc_inc = bus.in_pc + XLEN'(4);

  assign bus.in_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pc_q          <= '0;
      sel_q         <= '0;
      cnt           <= '0;
      halt_q        <= 1'b0;
      elem_start    <= '0;
      halted        <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_reg   <= '0;
      bus.out_pc    <= '0;
      bus.out_elem  <= '0;
      bus.out_err   <= ERR_OK;
    end else begin
      elem_start <= '0;
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            pc_q   <= bus.in_pc;
            halt_q <= 1'b0;
            if (dec_legal) begin
              sel_q      <= dec_sel;
              elem_start <= NUM_ELEM'(1) << dec_sel;
              state      <= ISSUE;
            end else begin
              sel_q         <= '0;
              bus.out_valid <= 1'b1;
              bus.out_reg   <= '0;
              bus.out_pc    <= in_pc_inc;
              bus.out_elem  <= '0;
              bus.out_err   <= ERR_ILL;
              state         <= RESP;
            end
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (done_sel) begin
            bus.out_valid <= 1'b1;
            bus.out_reg   <= res_sel;
            bus.out_pc    <= pcv_sel ? epc_sel : pc_inc;
            bus.out_elem  <= sel_q;
            bus.out_err   <= ERR_OK;
            halt_q        <= halt_req;
            state         <= RESP;
          end else if (cnt == CNT_LAST) begin
            cnt           <= cnt + 1'b1;
            bus.out_valid <= 1'b1;
            bus.out_reg   <= '0;
            bus.out_pc    <= pc_inc;
            bus.out_elem  <= sel_q;
            bus.out_err   <= ERR_TMO;
            state         <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (halt_q) begin
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              state <= IDLE;
            end
          end
        end
        HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_dispatch.sv
// tb_exec_dispatch: directed vectors for the dispatcher
// with hand-computed expected values.
module tb_exec_dispatch;
  import exec_dispatch_pkg::*;

  localparam int NE = 5;
  localparam int XL = 32;
  localparam int OW = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic [NE-1:0]   elem_start;
  logic [NE-1:0]   elem_done;
  logic [NE*XL-1:0] elem_result;
  logic [NE-1:0]   elem_pc_valid;
  logic [NE*XL-1:0] elem_pc;
  logic            halt_req;
  logic            halted;

  exec_dispatch_if #(
    .NUM_ELEM (NE),
    .XLEN     (XL),
    .OP_W     (OW)
  ) bus ();

  exec_dispatch dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .elem_start    (elem_start),
    .elem_done     (elem_done),
    .elem_result   (elem_result),
    .elem_pc_valid (elem_pc_valid),
    .elem_pc       (elem_pc),
    .halt_req      (halt_req),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  int          r_elem;
  logic [31:0] r_res;
  logic        r_pv;
  logic [31:0] r_pc;
  logic        r_halt;

  int          lat;
  logic [NE-1:0] st1;
  logic [NE-1:0] sa;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic chk_out(input string t,
                         input logic [31:0] reg_e,
                         input logic [31:0] pc_e,
                         input logic [2:0]  elem_e,
                         input logic [1:0]  err_e);
    check($sformatf("%s.valid", t), bus.out_valid, 1);
    check($sformatf("%s.reg", t), bus.out_reg, reg_e);
    check($sformatf("%s.pc", t), bus.out_pc, pc_e);
    check($sformatf("%s.elem", t), bus.out_elem, elem_e);
    check($sformatf("%s.err", t), bus.out_err, err_e);
  endtask

  // Offer one instruction, play the element, and return
  // the cycle count from accept to out_valid.
  task automatic do_op(input logic [5:0]  op,
                       input logic [31:0] pc,
                       input int          dly,
                       input bit          noise,
                       output int         l,
                       output logic [NE-1:0] s1,
                       output logic [NE-1:0] sall);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_pc    = pc;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    l    = 0;
    s1   = '0;
    sall = '0;
    for (int c = 1; c <= 300; c++) begin
      if (c == 1) s1 = elem_start;
      sall |= elem_start;
      if (bus.out_valid) begin
        l = c;
        break;
      end
      elem_done = '0;
      halt_req  = 1'b0;
      if (noise)
        elem_done = (c == 1) ? '1 : ~(NE'(1) << r_elem);
      if (dly > 0 && c == dly + 1) begin
        elem_done[r_elem]               = 1'b1;
        elem_result[r_elem*XL +: XL]    = r_res;
        elem_pc_valid[r_elem]           = r_pv;
        elem_pc[r_elem*XL +: XL]        = r_pc;
        halt_req                        = r_halt;
      end
      @(posedge clk);
      #1;
    end
    elem_done = '0;
    halt_req  = 1'b0;
  endtask

  task automatic take(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  logic [5:0] dop [13] =
    '{4, 7, 8, 27, 28, 31, 32, 47, 48, 53, 54, 3, 0};
  int dexp [13] =
    '{0, 0, 1, 1, 4, 4, 3, 3, 4, 4, 2, -1, -1};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    elem_done     = '0;
    halt_req      = 1'b0;
    elem_pc_valid = '1;
    r_halt        = 1'b0;
    for (int e = 0; e < NE; e++) begin
      elem_result[e*XL +: XL] = 32'hBAD0_0000 | e;
      elem_pc[e*XL +: XL]     = 32'hEE00_0000 | e;
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst.in_ready", bus.in_ready, 1);
    check("rst.out_valid", bus.out_valid, 0);
    check("rst.start", elem_start, 0);
    check("rst.halted", halted, 0);
    check("rst.out_reg", bus.out_reg, 0);
    check("rst.out_pc", bus.out_pc, 0);
    check("rst.out_elem", bus.out_elem, 0);
    check("rst.out_err", bus.out_err, 0);

    // op 10 -> elem1, done in 4th WAIT cycle, pc+4
    r_elem = 1; r_res = 32'hDEAD; r_pv = 0;
    r_pc = 32'h1234;
    do_op(6'd10, 32'h100, 4, 1'b1, lat, st1, sa);
    check("e1.lat", lat, 6);
    check("e1.start", st1, 5'b00010);
    check("e1.start_all", sa, 5'b00010);
    chk_out("e1", 32'hDEAD, 32'h104, 1, ERR_OK);
    take(0);
    check("e1.ready_after", bus.in_ready, 1);
    check("e1.valid_after", bus.out_valid, 0);

    // op 40 overlaps elem3/elem4 -> elem3, redirect pc
    r_elem = 3; r_res = 32'h1234_5678; r_pv = 1;
    r_pc = 32'h80;
    do_op(6'd40, 32'h200, 1, 1'b1, lat, st1, sa);
    check("e3.lat", lat, 3);
    check("e3.start", st1, 5'b01000);
    chk_out("e3", 32'h1234_5678, 32'h80, 3, ERR_OK);
    take(0);

    // illegal op, one-cycle response, no start
    do_op(6'd2, 32'h10, 0, 1'b0, lat, st1, sa);
    check("ill.lat", lat, 1);
    check("ill.start_all", sa, 0);
    chk_out("ill", 32'h0, 32'h14, 0, ERR_ILL);
    take(0);
    check("ill.ready_after", bus.in_ready, 1);

    // back-to-back: op 63 -> elem2, pc+4 wraps
    r_elem = 2; r_res = 32'hCAFE_F00D; r_pv = 0;
    r_pc = 32'h0;
    do_op(6'd63, 32'hFFFF_FFFC, 2, 1'b0, lat, st1, sa);
    check("wrap.lat", lat, 4);
    check("wrap.start", st1, 5'b00100);
    chk_out("wrap", 32'hCAFE_F00D, 32'h0, 2, ERR_OK);
    take(1);

    // range edges and holes
    for (int i = 0; i < 13; i++) begin
      r_res = 32'h0000_1000 + i;
      r_pv  = 0;
      if (dexp[i] >= 0) begin
        r_elem = dexp[i];
        do_op(dop[i], 32'h400, 1, 1'b0, lat, st1, sa);
        check($sformatf("dec%0d.lat", dop[i]), lat, 3);
        check($sformatf("dec%0d.start", dop[i]),
              st1, NE'(1) << dexp[i]);
        check($sformatf("dec%0d.elem", dop[i]),
              bus.out_elem, dexp[i]);
        check($sformatf("dec%0d.err", dop[i]),
              bus.out_err, ERR_OK);
      end else begin
        do_op(dop[i], 32'h400, 0, 1'b0, lat, st1, sa);
        check($sformatf("dec%0d.lat", dop[i]), lat, 1);
        check($sformatf("dec%0d.start", dop[i]), sa, 0);
        check($sformatf("dec%0d.err", dop[i]),
              bus.out_err, ERR_ILL);
      end
      take(0);
    end

    // op 30 -> elem4, never done: timeout after 255 WAIT
    r_elem = 4;
    do_op(6'd30, 32'h300, 0, 1'b0, lat, st1, sa);
    check("tmo.lat", lat, 257);
    check("tmo.valid", bus.out_valid, 1);
    check("tmo.reg", bus.out_reg, 0);
    check("tmo.pc", bus.out_pc, 32'h304);
    check("tmo.err", bus.out_err, ERR_TMO);
    elem_done[4] = 1'b1;
    elem_result[4*XL +: XL] = 32'h999;
    repeat (2) @(posedge clk);
    #1;
    elem_done = '0;
    check("tmo.late.reg", bus.out_reg, 0);
    check("tmo.late.err", bus.out_err, ERR_TMO);
    check("tmo.late.valid", bus.out_valid, 1);
    take(0);
    check("tmo.ready_after", bus.in_ready, 1);

    // op 5 -> elem0 with halt, stalled output
    r_elem = 0; r_res = 32'h55; r_pv = 0;
    r_pc = 32'h0; r_halt = 1;
    do_op(6'd5, 32'h40, 1, 1'b0, lat, st1, sa);
    r_halt = 0;
    check("halt.lat", lat, 3);
    chk_out("halt", 32'h55, 32'h44, 0, ERR_OK);
    elem_result[0 +: XL] = 32'hFFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("halt.hold%0d.valid", i),
            bus.out_valid, 1);
      check($sformatf("halt.hold%0d.reg", i),
            bus.out_reg, 32'h55);
      check($sformatf("halt.hold%0d.pc", i),
            bus.out_pc, 32'h44);
    end
    take(0);
    check("halt.halted", halted, 1);
    check("halt.in_ready", bus.in_ready, 0);
    check("halt.out_valid", bus.out_valid, 0);
    sa = '0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = 6'd10;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      sa |= elem_start;
    end
    bus.in_valid = 1'b0;
    check("halt.start_all", sa, 0);
    check("halt.still_halted", halted, 1);
    check("halt.still_not_ready", bus.in_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("halt.rst.halted", halted, 0);
    check("halt.rst.in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    // reset mid-WAIT of op 12 abandons the operation
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = 6'd12;
    bus.in_pc    = 32'h500;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("wrst.in_ready", bus.in_ready, 1);
    check("wrst.out_valid", bus.out_valid, 0);
    check("wrst.start", elem_start, 0);
    @(negedge clk);
    rst = 1'b0;
    elem_done[1] = 1'b1;
    sa = '0;
    lat = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      elem_done = '0;
      sa |= elem_start;
      if (bus.out_valid) lat = 1;
    end
    check("wrst.no_valid", lat, 0);
    check("wrst.no_start", sa, 0);
    check("wrst.ready", bus.in_ready, 1);
    r_elem = 1; r_res = 32'h7777; r_pv = 1;
    r_pc = 32'h900;
    do_op(6'd12, 32'h500, 2, 1'b0, lat, st1, sa);
    check("wrst.redo.lat", lat, 4);
    chk_out("wrst.redo", 32'h7777, 32'h900, 1, ERR_OK);
    take(0);
    check("wrst.redo.ready", bus.in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/exec_dispatch.md
EXEC_DISPATCH -- requirements
Module: exec_dispatch

Interface
REQ-001 SHALL have parameter NUM_ELEM, default 5, number of execution elements.
REQ-002 SHALL have parameter XLEN, default 32, datapath width.
REQ-003 SHALL have parameter OP_W, default 6, opcode width.
REQ-004 SHALL have parameter ELEM_LO[NUM_ELEM], default {4,8,54,32,28}, inclusive opcode lower bound per element.
REQ-005 SHALL have parameter ELEM_HI[NUM_ELEM], default {8,28,64,48,54}, exclusive opcode upper bound per element.
REQ-006 SHALL have parameter TIMEOUT, default 255, maximum WAIT cycles.
REQ-007 SHALL use one clock; reset is asynchronous and active-high: clk in 1, rising-edge clock; reset in 1, asynchronous active-high reset.
REQ-008 in_valid in 1, instruction offered; in_ready out 1, dispatcher accepts; in_pc in XLEN; in_op in OP_W.
REQ-009 elem_start out NUM_ELEM, one-hot start pulse; elem_done in NUM_ELEM; elem_result in NUM_ELEM*XLEN; elem_pc_valid in NUM_ELEM; elem_pc in NUM_ELEM*XLEN; halt_req in 1.
REQ-010 out_valid out 1; out_ready in 1; out_reg out XLEN; out_pc out XLEN; out_elem out clog2(NUM_ELEM); out_err out 2 (00 ok, 01 illegal, 10 timeout).
REQ-011 halted out 1, sticky halt indication.

Function
REQ-012 SHALL implement states IDLE, ISSUE, WAIT, RESP, HALT.
REQ-013 Decode: element e selected when ELEM_LO[e] <= op < ELEM_HI[e]; lowest index wins on overlap; no match = illegal.
REQ-014 in_ready=1 only in IDLE; on in_valid&in_ready latch pc/op; legal -> ISSUE, illegal -> RESP.
REQ-015 ISSUE lasts exactly one cycle, drives elem_start[sel]=1 (all other bits 0), clears timeout counter, -> WAIT.
REQ-016 WAIT samples only elem_done[sel]; done from other elements and any done during ISSUE ignored.
REQ-017 On elem_done[sel] in WAIT: latch out_reg=elem_result[sel]; out_pc=elem_pc[sel] if elem_pc_valid[sel] else pc+4 (mod 2^XLEN); out_err=00; latch halt_req; -> RESP.
REQ-018 WAIT counter increments each WAIT cycle without done; reaching TIMEOUT -> RESP with out_reg=0, out_pc=pc+4, out_err=10.
REQ-019 Illegal: out_reg=0, out_pc=pc+4, out_err=01, out_elem=0, no elem_start pulse.
REQ-020 RESP: out_valid=1, outputs stable until out_valid&out_ready; then -> HALT if latched halt_req else IDLE.
REQ-021 HALT: in_ready=0, halted=1, no starts; exit only via reset.
REQ-022 Minimum latency accept->out_valid: 3 cycles legal (done in first WAIT cycle), 1 cycle illegal; back-to-back accept the cycle after RESP handshake.
REQ-023 out_valid, elem_start SHALL be registered; no combinational path from in_valid to outputs.

Reset
REQ-024 Reset SHALL force IDLE; in_ready=1 after release; out_valid=0, elem_start=0, halted=0, out_reg=0, out_pc=0, out_elem=0, out_err=00, counter=0.
REQ-025 Reset asserted mid-WAIT or mid-RESP SHALL abandon the operation with no further output or start.

Structure
REQ-026 Package exec_dispatch_pkg SHALL hold state enum, err code constants, default ELEM_LO/ELEM_HI arrays.
REQ-027 Combinational sub-module exec_decode SHALL implement the range match (op -> sel, legal).

Verification
REQ-028 op=10, pc=0x100, elem1 done after 4 cycles result 0xDEAD, pc_valid=0 -> out_reg=0xDEAD, out_pc=0x104, out_elem=1, out_err=00.
REQ-029 op=40, pc=0x200, elem3 done pc_valid=1 pc=0x80 -> out_elem=3, out_pc=0x80 (overlap with elem4 resolved to 3).
REQ-030 op=2, pc=0x10 -> out_err=01, out_pc=0x14, one cycle after accept, no elem_start.
REQ-031 op=30, no done for 255 WAIT cycles -> out_err=10, out_reg=0; done arriving later ignored.
REQ-032 op=5, done with halt_req=1, out_ready held 0 for 3 cycles -> outputs stable, then HALT, halted=1, in_ready=0 until reset.
REQ-033 Reset during WAIT of op=12 -> in_ready=1 next cycle, out_valid never asserted, subsequent op=12 completes normally.
